ps2_mouse_init: RTL
===================

# ps2_mouse_init

Host-side PS/2 mouse configuration controller. After reset or on `start`, it takes ownership of the PS/2 clock and data lines and sends the mouse a fixed command sequence: reset, set sample rate 100, enable data reporting. It checks every response byte, then asserts `ready` to release the lines to the receive-only packet decoder that produces cursor x/y and button state. Open-drain drive is expressed as two active-high pull-low enables; the top level builds the tri-state pads.

## Interface
Parameters:
- INHIBIT_CYCLES, 10000: clock-low inhibit before request-to-send (100 µs at 100 MHz).
- BIT_TIMEOUT, 200000: max clk cycles between device clock falling edges inside a byte (2 ms).
- RESP_TIMEOUT, 60000000: max clk cycles waiting for a response start bit (600 ms, covers the BAT delay).
- MAX_RETRY, 3: full-sequence restarts before declaring failure.

Ports:
- clk  in  1  system clock.
- rst  in  1  one clock; reset is synchronous and active-low.
- start  in  1  pulse; restarts the sequence from step 0 when in DONE or FAIL; ignored otherwise.
- ps2c_in  in  1  raw PS/2 clock line (asynchronous).
- ps2d_in  in  1  raw PS/2 data line (asynchronous).
- ps2c_oe  out  1  1 = pull clock line low.
- ps2d_oe  out  1  1 = pull data line low.
- busy  out  1  sequence in progress.
- ready  out  1  mouse streaming; packet decoder may run.
- fail  out  1  retries exhausted; sticky until `start` or reset.
- retry_cnt  out  2  restarts consumed in the current run.

## Operation
- Inputs pass through a 2-flop synchronizer plus one history flop. A device clock falling edge is `prev & ~cur` on the synchronized clock. Data is sampled from the synchronized data line in the same cycle.
- Step table (command, expected responses):
  - FF → FA, AA, 00
  - F3 → FA
  - 64 → FA
  - F4 → FA
- States:
  - IDLE: after reset, goes to INHIBIT on the next cycle.
  - INHIBIT: ps2c_oe=1 for INHIBIT_CYCLES.
  - RTS: ps2d_oe=1 (start bit); ps2c_oe=0 one cycle later.
  - TX_BITS: on each falling edge, present the next bit: d0..d7 LSB first, then odd parity, then stop (ps2d_oe=0). A bit of value 0 means ps2d_oe=1.
  - TX_ACK: on the next falling edge, sample data; 0 = ACK, 1 = line NACK (error).
  - RX_WAIT: wait for a falling edge with data=0.
  - RX_BITS: shift in 8 data bits, parity, stop.
  - CHECK: compare the received byte with the expected byte.
  - NEXT: advance to the next response or the next step.
  - DONE, FAIL.
- After the final F4 ACK: DONE, ready=1, busy=0.
- Response 0xFE (resend) to a command: re-send the same byte, consuming one retry.
- Errors restart from step 0 via INHIBIT and increment retry_cnt: bad parity, stop bit = 0, wrong byte, line NACK, BIT_TIMEOUT, RESP_TIMEOUT.
- If retry_cnt == MAX_RETRY when an error occurs: FAIL, fail=1, both oe=0.
- A timeout counter reloads on every falling edge and on every state entry.
- Both oe outputs are 0 in every state except INHIBIT, RTS and TX_BITS.

## Timing
- Reset values: ps2c_oe=0, ps2d_oe=0, busy=0, ready=0, fail=0, retry_cnt=0. IDLE→INHIBIT on the first cycle after rst rises; busy=1 from that cycle.
- Edge detect latency: 3 clk from a raw line transition to the action. Bit changes in TX_BITS appear 1 clk after edge detection, well inside the device's clock-high window.
- INHIBIT holds exactly INHIBIT_CYCLES cycles. RTS holds ps2d_oe=1 alone with ps2c_oe=1 for 1 cycle, then releases ps2c_oe.
- ready rises 1 clk after CHECK accepts the final FA.
- `start` coincident with an error in FAIL/DONE: start wins and retry_cnt clears.
- rst low mid-byte: all outputs return to their reset values on the next edge and the lines are released immediately.

## Structure
- Package `ps2_pkg`: state enum, odd-parity function, step-table constants (command bytes, expected-response counts and values), ACK/RESEND byte constants.
- Sub-module `ps2_line_sync`: synchronizer plus falling-edge detector, reusable by the packet decoder.
- Counters: 27-bit timeout counter, 4-bit bit counter, 3-bit step index, 2-bit response index.

## Test plan
- Nominal: the mouse BFM acks every command and returns FA,AA,00 after FF → bytes sent on the wire are FF,F3,64,F4 with correct parity; ready=1, fail=0, retry_cnt=0.
- Resend: BFM answers FE to the first F3 → F3 is re-sent, sequence completes, retry_cnt=1.
- Bad parity on AA → restart from FF, retry_cnt=1, ready after the second pass.
- Silent device: no clock edges → RESP_TIMEOUT fires 4 times (MAX_RETRY=3), then fail=1, ps2c_oe=ps2d_oe=0. A `start` pulse clears fail and re-enters INHIBIT.
- Inhibit check: ps2c_oe high for exactly 10000 cycles; ps2d_oe rises before ps2c_oe falls.
- Reset asserted during the TX_BITS of F4 → both oe=0 and ready=0 on the next clk; after release the sequence restarts cleanly from FF.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse host: FSM states, odd parity and the
// fixed configuration command/response table.
package ps2_pkg;

    localparam int unsigned TMR_W     = 27;
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned STEP_W    = 3;
    localparam int unsigned RESP_W    = 2;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(3);

    localparam logic [7:0] ACK_BYTE       = 8'hFA;
    localparam logic [7:0] RESEND_BYTE    = 8'hFE;
    localparam logic [7:0] BAT_OK_BYTE    = 8'hAA;
    localparam logic [7:0] DEVICE_ID_BYTE = 8'h00;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_RATE_100 = 8'h64;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_TX_BITS,
        ST_TX_ACK,
        ST_RX_WAIT,
        ST_RX_BITS,
        ST_CHECK,
        ST_NEXT,
        ST_DONE,
        ST_FAIL
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic logic [7:0] step_cmd(input logic [STEP_W-1:0] step);
        case (step)
            STEP_W'(0): return CMD_RESET;
            STEP_W'(1): return CMD_SET_RATE;
            STEP_W'(2): return CMD_RATE_100;
            default:    return CMD_ENABLE;
        endcase
    endfunction

    // Only the reset command answers with more than the ACK (ACK, BAT result, ID).
    function automatic logic [RESP_W-1:0] step_resp_cnt(input logic [STEP_W-1:0] step);
        return (step == STEP_W'(0)) ? RESP_W'(3) : RESP_W'(1);
    endfunction

    function automatic logic [7:0] step_resp(input logic [STEP_W-1:0] step,
                                             input logic [RESP_W-1:0] idx);
        if (step != STEP_W'(0)) return ACK_BYTE;
        case (idx)
            RESP_W'(0): return ACK_BYTE;
            RESP_W'(1): return BAT_OK_BYTE;
            default:    return DEVICE_ID_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the raw PS/2 clock/data lines and flags device clock falling edges.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2c_in,
    input  logic ps2d_in,
    output logic clk_fall_c,
    output logic data_sync
);

    logic c_meta;
    logic c_sync;
    logic c_prev;
    logic d_meta;

    // Idle-high reset values so leaving reset never fakes a falling edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            c_meta    <= 1'b1;
            c_sync    <= 1'b1;
            c_prev    <= 1'b1;
            d_meta    <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            c_meta    <= ps2c_in;
            c_sync    <= c_meta;
            c_prev    <= c_sync;
            d_meta    <= ps2d_in;
            data_sync <= d_meta;
        end
    end

    assign clk_fall_c = c_prev & ~c_sync;

endmodule

// File: rtl/ps2_mouse_init.sv
// PS/2 mouse configuration controller: sends FF, F3, 64, F4 with response
// checking and retries, then hands the lines to the packet decoder via ready.
module ps2_mouse_init
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned BIT_TIMEOUT    = 200000,
    parameter int unsigned RESP_TIMEOUT   = 60000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    state_t                state;
    logic [TMR_W-1:0]      timer;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [STEP_W-1:0]     step;
    logic [RESP_W-1:0]     resp_idx;
    logic [9:0]            tx_shift;
    logic [7:0]            rx_byte;
    logic                  rx_par;
    logic                  rx_stop;

    logic                  clk_fall_c;
    logic                  data_s;
    logic [TMR_W-1:0]      tmr_limit_c;
    logic [7:0]            cmd_c;
    logic                  line_active_c;
    logic                  timeout_c;
    logic                  frame_ok_c;
    logic                  byte_ok_c;
    logic                  resend_c;
    logic                  check_bad_c;
    logic                  err_c;
    logic                  abort_c;
    logic                  retry_left_c;

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2c_in    (ps2c_in),
        .ps2d_in    (ps2d_in),
        .clk_fall_c (clk_fall_c),
        .data_sync  (data_s)
    );

    // The first device clock of a command may come late, so it shares the response bound.
    always_comb begin
        tmr_limit_c = TMR_W'(BIT_TIMEOUT - 1);
        if (state == ST_RX_WAIT || (state == ST_TX_BITS && bit_cnt == BIT_CNT_W'(0)))
            tmr_limit_c = TMR_W'(RESP_TIMEOUT - 1);
    end

    always_comb begin
        cmd_c         = step_cmd(step);
        line_active_c = state inside {ST_TX_BITS, ST_TX_ACK, ST_RX_WAIT, ST_RX_BITS};
        timeout_c     = line_active_c && !clk_fall_c && (timer == tmr_limit_c);
        frame_ok_c    = rx_stop && (rx_par == odd_parity(rx_byte));
        byte_ok_c     = frame_ok_c && (rx_byte == step_resp(step, resp_idx));
        resend_c      = frame_ok_c && (resp_idx == RESP_W'(0)) && (rx_byte == RESEND_BYTE);
        check_bad_c   = (state == ST_CHECK) && !byte_ok_c;
        err_c         = timeout_c
                     || (state == ST_TX_ACK && clk_fall_c && data_s)
                     || (check_bad_c && !resend_c);
        abort_c       = err_c || check_bad_c;
        retry_left_c  = (retry_cnt != 2'(MAX_RETRY));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ps2c_oe   <= 1'b0;
            ps2d_oe   <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 2'd0;
            timer     <= '0;
            bit_cnt   <= '0;
            step      <= '0;
            resp_idx  <= '0;
            tx_shift  <= '0;
            rx_byte   <= '0;
            rx_par    <= 1'b0;
            rx_stop   <= 1'b0;
        end else begin
            timer <= timer + TMR_W'(1);
            if (line_active_c && clk_fall_c)
                timer <= '0;

            case (state)
                ST_IDLE: begin
                    state   <= ST_INHIBIT;
                    busy    <= 1'b1;
                    ps2c_oe <= 1'b1;
                    timer   <= '0;
                end

                // Last inhibit cycle overlaps the start bit in RTS.
                ST_INHIBIT: begin
                    if (timer == TMR_W'(INHIBIT_CYCLES - 2)) begin
                        state   <= ST_RTS;
                        ps2d_oe <= 1'b1;
                        timer   <= '0;
                    end
                end

                ST_RTS: begin
                    state    <= ST_TX_BITS;
                    ps2c_oe  <= 1'b0;
                    tx_shift <= {1'b1, odd_parity(cmd_c), cmd_c};
                    bit_cnt  <= '0;
                    timer    <= '0;
                end

                ST_TX_BITS: begin
                    if (clk_fall_c) begin
                        ps2d_oe  <= ~tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == BIT_CNT_W'(9)) begin
                            state <= ST_TX_ACK;
                            timer <= '0;
                        end
                    end
                end

                ST_TX_ACK: begin
                    if (clk_fall_c && !data_s) begin
                        state    <= ST_RX_WAIT;
                        resp_idx <= '0;
                        timer    <= '0;
                    end
                end

                ST_RX_WAIT: begin
                    if (clk_fall_c && !data_s) begin
                        state   <= ST_RX_BITS;
                        bit_cnt <= '0;
                        timer   <= '0;
                    end
                end

                ST_RX_BITS: begin
                    if (clk_fall_c) begin
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt < BIT_CNT_W'(8)) begin
                            rx_byte <= {data_s, rx_byte[7:1]};
                        end else if (bit_cnt == BIT_CNT_W'(8)) begin
                            rx_par <= data_s;
                        end else begin
                            rx_stop <= data_s;
                            state   <= ST_CHECK;
                            timer   <= '0;
                        end
                    end
                end

                ST_CHECK: begin
                    if (byte_ok_c)
                        state <= ST_NEXT;
                end

                ST_NEXT: begin
                    timer <= '0;
                    if (resp_idx != step_resp_cnt(step) - RESP_W'(1)) begin
                        resp_idx <= resp_idx + RESP_W'(1);
                        state    <= ST_RX_WAIT;
                    end else if (step == LAST_STEP) begin
                        state <= ST_DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        step     <= step + STEP_W'(1);
                        resp_idx <= '0;
                        state    <= ST_INHIBIT;
                        ps2c_oe  <= 1'b1;
                        ps2d_oe  <= 1'b0;
                    end
                end

                ST_DONE, ST_FAIL: begin
                    if (start) begin
                        state     <= ST_INHIBIT;
                        step      <= '0;
                        resp_idx  <= '0;
                        retry_cnt <= 2'd0;
                        fail      <= 1'b0;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                        ps2c_oe   <= 1'b1;
                        ps2d_oe   <= 1'b0;
                        timer     <= '0;
                    end
                end

                default: state <= ST_IDLE;
            endcase

            // Errors restart from the reset command; a resend repeats the current one.
            if (abort_c) begin
                timer    <= '0;
                resp_idx <= '0;
                if (!retry_left_c) begin
                    state   <= ST_FAIL;
                    fail    <= 1'b1;
                    busy    <= 1'b0;
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                end else begin
                    state     <= ST_INHIBIT;
                    ps2c_oe   <= 1'b1;
                    ps2d_oe   <= 1'b0;
                    retry_cnt <= retry_cnt + 2'd1;
                    if (err_c)
                        step <= '0;
                end
            end
        end
    end

endmodule
